// File: rtl/seq_mult8_ctrl_pkg.sv
// Shared constants and FSM state encoding for the 8x8 shift-and-add multiplier controller.
package seq_mult8_ctrl_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 2 * OP_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mult8_ctrl.sv
// Sequential shift-and-add multiplier controller driving an external 2*OP_W adder.
// Optional macro SEQ_MULT_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
module seq_mult8_ctrl #(
  parameter int OP_W = seq_mult8_ctrl_pkg::OP_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [OP_W-1:0]     a,
  input  logic [OP_W-1:0]     b,
  output logic [2*OP_W-1:0]   add_a,
  output logic [2*OP_W-1:0]   add_b,
  input  logic [2*OP_W-1:0]   add_sum,
  output logic                busy,
  output logic                done,
  output logic [2*OP_W-1:0]   product
);

  import seq_mult8_ctrl_pkg::*;

  localparam int PW = 2 * OP_W;
  localparam int CW = (OP_W > 1) ? $clog2(OP_W) : 1;
  localparam logic [CW-1:0] LAST_C = CW'(OP_W - 1);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  state_t          r_state;
  logic            r_busy;
  logic            r_done;
  logic [PW-1:0]   r_acc;
  logic [PW-1:0]   r_mcand;
  logic [OP_W-1:0] r_mplr;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_product;

  state_t          w_state_nxt;
  logic            w_load;
  logic            w_step;
  logic            w_finish;
  logic [PW-1:0]   w_prod_nxt;
  logic [PW-1:0]   w_add_a;
  logic [PW-1:0]   w_add_b;

  assign add_a   = w_add_a;
  assign add_b   = w_add_b;
  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

  // State register; busy/done are registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == RUN);
      r_done  <= (w_state_nxt == DONE);
    end
  end

  // Next-state decode and adder operand selection.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    w_prod_nxt  = {PW{1'b0}};
    w_add_a     = {PW{1'b0}};
    w_add_b     = {PW{1'b0}};
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        w_add_a = r_acc;
        if (r_mplr[0]) begin
          w_add_b = r_mcand;
        end else begin
          w_add_b = {PW{1'b0}};
        end
`ifdef SEQ_MULT_EARLY_EXIT_EN
        // No multiplier bits left: the accumulator already holds the product.
        if (r_mplr == {OP_W{1'b0}}) begin
          w_finish    = 1'b1;
          w_prod_nxt  = r_acc;
          w_state_nxt = DONE;
        end else begin
          w_step = 1'b1;
          if (r_count == LAST_C) begin
            w_finish    = 1'b1;
            w_prod_nxt  = add_sum;
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = RUN;
          end
        end
`else
        w_step = 1'b1;
        if (r_count == LAST_C) begin
          w_finish    = 1'b1;
          w_prod_nxt  = add_sum;
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = RUN;
        end
`endif
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Operand latch, shift-and-add datapath and product capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc     <= {PW{1'b0}};
      r_mcand   <= {PW{1'b0}};
      r_mplr    <= {OP_W{1'b0}};
      r_count   <= {CW{1'b0}};
      r_product <= {PW{1'b0}};
    end else begin
      if (w_load) begin
        r_acc   <= {PW{1'b0}};
        r_mcand <= {{OP_W{1'b0}}, a};
        r_mplr  <= b;
        r_count <= {CW{1'b0}};
      end else if (w_step) begin
        r_acc   <= add_sum;
        r_mcand <= {r_mcand[PW-2:0], 1'b0};
        r_mplr  <= {1'b0, r_mplr[OP_W-1:1]};
        r_count <= r_count + ONE_C;
      end else begin
        r_acc   <= r_acc;
        r_mcand <= r_mcand;
        r_mplr  <= r_mplr;
        r_count <= r_count;
      end
      if (w_finish) begin
        r_product <= w_prod_nxt;
      end else begin
        r_product <= r_product;
      end
    end
  end

endmodule
